// File: rtl/img_pkg.sv
// Shared constants for the gray-frame path: frame geometry, luma
// coefficients and the loader state encoding.
package img_pkg;

  localparam int W               = 64;
  localparam int H               = 64;
  localparam int TOTAL_PIXEL     = W * H;
  localparam int TOTAL_PIXEL_BIT = $clog2(W * H);
  // One extra bit so the counter can sit at TOTAL_PIXEL while a finished
  // frame is waiting to be acknowledged.
  localparam int CNT_W           = TOTAL_PIXEL_BIT + 1;

  // Coefficients sum to 256, so full white maps to exactly 255.
  localparam logic [7:0]  COEF_R     = 8'd77;
  localparam logic [7:0]  COEF_G     = 8'd150;
  localparam logic [7:0]  COEF_B     = 8'd29;
  localparam logic [15:0] LUMA_ROUND = 16'd128;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/rgb2gray_loader_if.sv
// Valid/ready RGB pixel stream into the loader.
interface rgb2gray_loader_if;

  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/rgb2gray_loader_luma_pipe.sv
// Two-stage RGB -> 8-bit luma datapath with valid and address sidebands.
// Stage 1 registers the three products; stage 2 registers the rounded sum.
module luma_pipe
  import img_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [23:0]                in_data,
  input  logic [TOTAL_PIXEL_BIT-1:0] in_addr,
  output logic                       out_valid,
  output logic [TOTAL_PIXEL_BIT-1:0] out_addr,
  output logic [7:0]                 out_data
);

  logic                       v1_r;
  logic [15:0]                red_prod_r;
  logic [15:0]                grn_prod_r;
  logic [15:0]                blu_prod_r;
  logic [TOTAL_PIXEL_BIT-1:0] addr1_r;
  logic [15:0]                sum_s;

  // Stage 1 valid: tracks accepted beats, cleared on reset to drop them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
    end else begin
      v1_r <= in_valid;
    end
  end

  // Stage 1 data: products and address, loaded only on accepted beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_prod_r <= 16'd0;
      grn_prod_r <= 16'd0;
      blu_prod_r <= 16'd0;
      addr1_r    <= {TOTAL_PIXEL_BIT{1'b0}};
    end else if (in_valid) begin
      red_prod_r <= {8'd0, COEF_R} * {8'd0, in_data[23:16]};
      grn_prod_r <= {8'd0, COEF_G} * {8'd0, in_data[15:8]};
      blu_prod_r <= {8'd0, COEF_B} * {8'd0, in_data[7:0]};
      addr1_r    <= in_addr;
    end
  end

  // Max sum is 255*256 + 128 = 65408, so 16 bits hold it and the
  // upper byte is already a valid 0..255 luma.
  assign sum_s = red_prod_r + grn_prod_r + blu_prod_r + LUMA_ROUND;

  // Stage 2: registered BRAM write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_addr  <= {TOTAL_PIXEL_BIT{1'b0}};
      out_data  <= 8'd0;
    end else begin
      out_valid <= v1_r;
      if (v1_r) begin
        out_addr <= addr1_r;
        out_data <= 8'(sum_s >> 4'd8);
      end
    end
  end

endmodule

// File: rtl/rgb2gray_loader.sv
// Loads one RGB frame as luma into the gray BRAM, then holds the stream
// off until the equaliser acknowledges the frame.
module rgb2gray_loader
  import img_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  rgb2gray_loader_if.slave           s,
  output logic                       wr_en,
  output logic [TOTAL_PIXEL_BIT-1:0] wr_addr,
  output logic [7:0]                 wr_data,
  output logic                       frame_valid,
  input  logic                       frame_ack,
  output logic                       sync_err
);

  localparam logic [CNT_W-1:0]           LAST_IDX  = CNT_W'(TOTAL_PIXEL - 1);
  localparam logic [CNT_W-1:0]           CNT_ONE   = CNT_W'(1);
  localparam logic [TOTAL_PIXEL_BIT-1:0] LAST_ADDR = TOTAL_PIXEL_BIT'(TOTAL_PIXEL - 1);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             s_ready_r;
  logic             frame_valid_r;
  logic             sync_err_r;
  logic             sync_err_s;
  logic             beat_s;

  // s_ready is a register, so a beat never depends combinationally on s_valid
  assign beat_s      = s.s_valid & s_ready_r;
  assign s.s_ready   = s_ready_r;
  assign frame_valid = frame_valid_r;
  assign sync_err    = sync_err_r;

  // Next-state, counter and framing-error decode
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    sync_err_s = 1'b0;
    case (state_r)
      FILL: begin
        if (beat_s) begin
          if (cnt_r == LAST_IDX) begin
            // Final pixel: the frame is kept even if s_last is missing
            state_s    = FLUSH;
            cnt_s      = cnt_r + CNT_ONE;
            sync_err_s = ~s.s_last;
          end else if (s.s_last) begin
            // Early s_last: beat is written, partial frame is abandoned
            cnt_s      = {CNT_W{1'b0}};
            sync_err_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      FLUSH: begin
        // No beats are accepted here, so the last write is the final pixel
        if (wr_en && (wr_addr == LAST_ADDR)) begin
          state_s = HOLD;
        end else begin
          state_s = FLUSH;
        end
      end
      HOLD: begin
        if (frame_ack) begin
          state_s = FILL;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = FILL;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= FILL;
      cnt_r         <= {CNT_W{1'b0}};
      s_ready_r     <= 1'b0;
      frame_valid_r <= 1'b0;
      sync_err_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      s_ready_r     <= (state_s == FILL);
      frame_valid_r <= (state_s == HOLD);
      sync_err_r    <= sync_err_s;
    end
  end

  luma_pipe u_luma_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (beat_s),
    .in_data   (s.s_data),
    .in_addr   (cnt_r[TOTAL_PIXEL_BIT-1:0]),
    .out_valid (wr_en),
    .out_addr  (wr_addr),
    .out_data  (wr_data)
  );

endmodule
